// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter: shares one single-port memory between IF and M, with
// M priority and an IF anti-starvation streak limit. Option: MEMARB_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int STREAK_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        m_req,
  input  logic        m_we,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  output logic [31:0] m_rdata,
  output logic        m_ready,
  output logic        stall_F,
  output logic        stall_M,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err
);

  localparam int SW = $clog2(STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_LIM = SW'(STREAK_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic          owner;
  logic [SW-1:0] streak;
  logic          grant_m;
  logic          grant_if;
  logic          timed_out;

  assign stall_F  = if_req & ~if_ready;
  assign stall_M  = m_req & ~m_ready;
  assign grant_m  = m_req && (!if_req || (streak != STREAK_LIM));
  assign grant_if = if_req && !grant_m;

`ifdef MEMARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tcnt;
  logic          err_r;

  // An ack in the limit cycle wins over the timeout.
  assign timed_out = (state == BUSY) && !mem_ack && (tcnt == T_LAST);
  assign err       = err_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt  <= '0;
      err_r <= 1'b0;
    end else begin
      if ((state == BUSY) && !mem_ack && !timed_out) begin
        tcnt <= tcnt + 1'b1;
      end else begin
        tcnt <= '0;
      end
      if (timed_out) begin
        err_r <= 1'b1;
      end
    end
  end
`else
  assign timed_out = 1'b0;
  // TIMEOUT only matters when the watchdog is compiled in.
  assign err       = 1'b0 & (TIMEOUT > 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      streak    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      m_rdata   <= '0;
      if_ready  <= 1'b0;
      m_ready   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_m) begin
            owner     <= 1'b1;
            mem_we    <= m_we;
            mem_addr  <= m_addr;
            mem_wdata <= m_wdata;
            mem_req   <= 1'b1;
            state     <= BUSY;
            if (!if_req) begin
              streak <= '0;
            end else if (streak != STREAK_LIM) begin
              streak <= streak + 1'b1;
            end
          end else if (grant_if) begin
            owner     <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_req   <= 1'b1;
            state     <= BUSY;
            streak    <= '0;
          end
        end
        BUSY: begin
          if (mem_ack || timed_out) begin
            mem_req <= 1'b0;
            state   <= DONE;
            if (owner) begin
              m_rdata <= mem_ack ? mem_rdata : 32'h0;
              m_ready <= 1'b1;
            end else begin
              if_rdata <= mem_ack ? mem_rdata : 32'h0;
              if_ready <= 1'b1;
            end
          end
        end
        DONE: begin
          // Requests still reflect the access just completed; ignore them here.
          if_ready <= 1'b0;
          m_ready  <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// tb_mem_port_arbiter: directed stimulus with scoreboard queues for memory
// requests and ready responses, checked by separate responder/monitor processes.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req, m_req, m_we, mem_ack;
  logic [31:0] if_addr, m_addr, m_wdata, mem_rdata;
  logic [31:0] if_rdata, m_rdata, mem_addr, mem_wdata;
  logic        if_ready, m_ready, stall_F, stall_M, mem_req, mem_we, err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STREAK_MAX(4), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .stall_F(stall_F), .stall_M(stall_M),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          waits;  // -1 = never acknowledge
    logic [31:0] rdata;
  } mem_t;
  typedef struct {
    logic        port;   // 0 = IF, 1 = M
    logic [31:0] rdata;
  } rsp_t;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mreq_t;

  mem_t        mem_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] if_q[$];
  mreq_t       m_q[$];

  int checks = 0;
  int failures = 0;
  bit flush = 1'b0;
  int stray_req = 0;
  int last_busy = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_mem(logic [31:0] a, logic we, logic [31:0] d, int w, logic [31:0] r);
    mem_t t;
    t.addr = a; t.we = we; t.wdata = d; t.waits = w; t.rdata = r;
    mem_q.push_back(t);
  endtask

  task automatic exp_rsp(logic port, logic [31:0] r);
    rsp_t t;
    t.port = port; t.rdata = r;
    rsp_q.push_back(t);
  endtask

  task automatic push_m(logic we, logic [31:0] a, logic [31:0] d);
    mreq_t t;
    t.we = we; t.addr = a; t.wdata = d;
    m_q.push_back(t);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(string name, int budget);
    int n = 0;
    while ((rsp_q.size() != 0 || if_q.size() != 0 || m_q.size() != 0 ||
            if_req || m_req || mem_req) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required completion", name, n);
    end
    step();
    check({name, "_mem_q_left"}, 32'(mem_q.size()), 32'd0);
  endtask

  // IF requester: advances on the edge that ends its ready cycle.
  initial begin
    if_req = 1'b0; if_addr = '0;
    forever begin
      @(negedge clk);
      if (flush) begin
        if_req = 1'b0;
        if_q.delete();
      end else begin
        if (if_req && if_ready) if_req = 1'b0;
        if (!if_req && if_q.size() > 0) begin
          if_addr = if_q.pop_front();
          if_req  = 1'b1;
        end
      end
    end
  end

  // M requester.
  initial begin
    mreq_t t;
    m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    forever begin
      @(negedge clk);
      if (flush) begin
        m_req = 1'b0;
        m_q.delete();
      end else begin
        if (m_req && m_ready) m_req = 1'b0;
        if (!m_req && m_q.size() > 0) begin
          t = m_q.pop_front();
          m_we = t.we; m_addr = t.addr; m_wdata = t.wdata;
          m_req = 1'b1;
        end
      end
    end
  end

  // Memory responder: checks each BUSY cycle against the expected request.
  initial begin
    int   seen_stray;
    bit   busy;
    int   bcnt;
    mem_t cur;
    seen_stray = 0; busy = 1'b0; bcnt = 0;
    cur.addr = '0; cur.we = 1'b0; cur.wdata = '0; cur.waits = 0; cur.rdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (stray_req != seen_stray) begin
        seen_stray = stray_req;
        mem_ack    = 1'b1;
        mem_rdata  = 32'hBAD0BAD0;
      end else if (mem_req) begin
        if (!busy) begin
          busy = 1'b1;
          bcnt = 0;
          checks++;
          if (mem_q.size() == 0) begin
            failures++;
            $display("FAIL mem_unexpected: got mem_req addr 0x%08h, required no request", mem_addr);
            cur.addr = 32'hFFFFFFFF; cur.we = 1'b0; cur.wdata = '0; cur.waits = 0; cur.rdata = '0;
          end else begin
            cur = mem_q.pop_front();
          end
        end
        bcnt++;
        check("mem_addr", mem_addr, cur.addr);
        check("mem_we", 32'(mem_we), 32'(cur.we));
        check("mem_wdata", mem_wdata, cur.wdata);
        if (cur.waits >= 0 && bcnt == cur.waits + 1) begin
          mem_ack   = 1'b1;
          mem_rdata = cur.rdata;
          busy      = 1'b0;
          last_busy = bcnt;
        end
      end else if (busy) begin
        busy      = 1'b0;
        last_busy = bcnt;
      end
    end
  end

  // Response monitor: pops the scoreboard whenever a ready pulse appears.
  initial begin
    bit   pif, pm, pack;
    rsp_t e;
    pif = 1'b0; pm = 1'b0; pack = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        pif = 1'b0; pm = 1'b0; pack = 1'b0;
      end else begin
        check("stall_F", 32'(stall_F), 32'(if_req & ~if_ready));
        check("stall_M", 32'(stall_M), 32'(m_req & ~m_ready));
        if (if_ready || m_ready) begin
          checks++;
          if (!(pack || err)) begin
            failures++;
            $display("FAIL ready_latency: ready without ack in previous cycle, required ack one cycle earlier");
          end
          checks++;
          if (if_ready && m_ready) begin
            failures++;
            $display("FAIL ready_both: got if_ready=1 m_ready=1, required one owner");
          end
          checks++;
          if (rsp_q.size() == 0) begin
            failures++;
            $display("FAIL ready_unexpected: got if_ready=%0b m_ready=%0b, required none", if_ready, m_ready);
          end else begin
            e = rsp_q.pop_front();
            check("ready_port", 32'(m_ready), 32'(e.port));
            if (e.port) check("m_rdata", m_rdata, e.rdata);
            else        check("if_rdata", if_rdata, e.rdata);
          end
        end
        if ((if_ready && pif) || (m_ready && pm)) begin
          checks++;
          failures++;
          $display("FAIL ready_pulse: ready high for 2 cycles, required 1");
        end
        pif  = if_ready;
        pm   = m_ready;
        pack = mem_ack && mem_req;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_if_ready", 32'(if_ready), 32'd0);
    check("rst_m_ready", 32'(m_ready), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_m_rdata", m_rdata, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    step();

    // IF only, ack in cycle 1.
    exp_mem(32'h4, 1'b0, 32'h0, 0, 32'h2002000A);
    exp_rsp(1'b0, 32'h2002000A);
    if_q.push_back(32'h4);
    @(negedge clk); #1;
    check("if_c0_stall_F", 32'(stall_F), 32'd1);
    step();
    check("if_c1_mem_req", 32'(mem_req), 32'd1);
    check("if_c1_mem_addr", mem_addr, 32'h4);
    check("if_c1_stall_F", 32'(stall_F), 32'd1);
    step();
    check("if_c2_if_ready", 32'(if_ready), 32'd1);
    check("if_c2_if_rdata", if_rdata, 32'h2002000A);
    check("if_c2_stall_F", 32'(stall_F), 32'd0);
    wait_done("if_only", 20);

    // Contention: M first, IF next.
    exp_mem(32'h10, 1'b0, 32'h0, 0, 32'h11110000);
    exp_mem(32'h8, 1'b0, 32'h0, 0, 32'h22220000);
    exp_rsp(1'b1, 32'h11110000);
    exp_rsp(1'b0, 32'h22220000);
    push_m(1'b0, 32'h10, 32'h0);
    if_q.push_back(32'h8);
    step();
    check("cont_first_addr", mem_addr, 32'h10);
    check("cont_stall_F", 32'(stall_F), 32'd1);
    wait_done("contention", 30);

    // Streak: four M grants, then IF, then M (streak cleared), then IF.
    exp_mem(32'h100, 1'b0, 32'h0, 0, 32'hA5A50100);
    exp_mem(32'h104, 1'b0, 32'h0, 0, 32'hA5A50104);
    exp_mem(32'h108, 1'b0, 32'h0, 0, 32'hA5A50108);
    exp_mem(32'h10C, 1'b0, 32'h0, 0, 32'hA5A5010C);
    exp_mem(32'h200, 1'b0, 32'h0, 0, 32'hA5A50200);
    exp_mem(32'h110, 1'b0, 32'h0, 0, 32'hA5A50110);
    exp_mem(32'h204, 1'b0, 32'h0, 0, 32'hA5A50204);
    exp_rsp(1'b1, 32'hA5A50100);
    exp_rsp(1'b1, 32'hA5A50104);
    exp_rsp(1'b1, 32'hA5A50108);
    exp_rsp(1'b1, 32'hA5A5010C);
    exp_rsp(1'b0, 32'hA5A50200);
    exp_rsp(1'b1, 32'hA5A50110);
    exp_rsp(1'b0, 32'hA5A50204);
    push_m(1'b0, 32'h100, 32'h0);
    push_m(1'b0, 32'h104, 32'h0);
    push_m(1'b0, 32'h108, 32'h0);
    push_m(1'b0, 32'h10C, 32'h0);
    push_m(1'b0, 32'h110, 32'h0);
    if_q.push_back(32'h200);
    if_q.push_back(32'h204);
    wait_done("streak", 60);

    // Store with three wait states.
    exp_mem(32'h20, 1'b1, 32'h55, 3, 32'hCAFE0020);
    exp_rsp(1'b1, 32'hCAFE0020);
    push_m(1'b1, 32'h20, 32'h55);
    wait_done("store", 30);
    check("store_busy_cycles", 32'(last_busy), 32'd4);

    // Reset in the second BUSY cycle, then a stray ack.
    exp_mem(32'h30, 1'b0, 32'h0, -1, 32'h0);
    push_m(1'b0, 32'h30, 32'h0);
    n = 0;
    while (!mem_req && n < 10) begin
      step();
      n++;
    end
    check("rstb_mem_req_seen", 32'(mem_req), 32'd1);
    step();
    rst = 1'b1;
    flush = 1'b1;
    step();
    check("rstb_mem_req", 32'(mem_req), 32'd0);
    check("rstb_m_ready", 32'(m_ready), 32'd0);
    check("rstb_mem_addr", mem_addr, 32'd0);
    rst = 1'b0;
    flush = 1'b0;
    step();
    check("rstb_busy_cycles", 32'(last_busy), 32'd2);
    stray_req++;
    repeat (4) begin
      step();
      check("stray_m_ready", 32'(m_ready), 32'd0);
      check("stray_mem_req", 32'(mem_req), 32'd0);
    end
    check("stray_m_rdata", m_rdata, 32'd0);
    check("stray_if_rdata", if_rdata, 32'd0);
    exp_mem(32'h40, 1'b0, 32'h0, 1, 32'h12345678);
    exp_rsp(1'b0, 32'h12345678);
    if_q.push_back(32'h40);
    wait_done("after_reset", 20);

`ifdef MEMARB_TIMEOUT_EN
    // No ack: watchdog completes the access with rdata=0 and sets err.
    exp_mem(32'h50, 1'b0, 32'h0, -1, 32'h0);
    exp_rsp(1'b1, 32'h0);
    push_m(1'b0, 32'h50, 32'h0);
    wait_done("timeout", 400);
    check("timeout_busy_cycles", 32'(last_busy), 32'd255);
    check("timeout_err", 32'(err), 32'd1);
    repeat (5) step();
    check("timeout_err_held", 32'(err), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("timeout_err_rst", 32'(err), 32'd0);
`else
    check("err_tied_low", 32'(err), 32'd0);
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencing controller that shares one single-port unified instruction/data memory between the fetch stage (IF) and the memory stage (M) of the pipelined MIPS core. It arbitrates requests, drives the memory handshake and produces the stall signals that freeze the pipeline registers, including the EX/M register, while an access is outstanding. M has priority over IF, with a streak limit that prevents IF starvation.

## Interface
- STREAK_MAX, 4: consecutive M grants allowed while IF is waiting; the next contended grant goes to IF.
- TIMEOUT, 255: wait-state limit in BUSY; used only when MEMARB_TIMEOUT_EN is defined.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  32  fetch byte address.
- if_rdata  out  32  fetched word; valid while if_ready=1.
- if_ready  out  1  one-cycle completion pulse to IF.
- m_req  in  1  data request (MemtoReg_M | MemWrite_M); held until m_ready.
- m_we  in  1  data write enable (MemWrite_M).
- m_addr  in  32  data address (ALUResult_M).
- m_wdata  in  32  store data (WriteData_M).
- m_rdata  out  32  load data; valid while m_ready=1.
- m_ready  out  1  one-cycle completion pulse to M.
- stall_F  out  1  IF stall = if_req & ~if_ready.
- stall_M  out  1  stall for the M stage and everything upstream = m_req & ~m_ready.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; sampled in the same cycle as mem_ack.
- mem_ack  in  1  memory completion, one cycle.
- err  out  1  sticky timeout flag.

## Operation
- States: IDLE, BUSY, DONE. A 1-bit register `owner` records the granted requester (0 = IF, 1 = M).
- IDLE: if m_req and if_req are both high, M wins unless streak == STREAK_MAX, in which case IF wins. If only one request is high, that requester wins. If neither is high, the FSM stays in IDLE. On any grant, the FSM latches the owner's addr, wdata and we (0 for IF) into mem_* registers and moves to BUSY.
- BUSY: mem_req=1 and mem_* are held stable. On mem_ack=1, mem_rdata is latched into the owner's rdata register, mem_req drops and the FSM moves to DONE.
- DONE: the owner's ready=1 for exactly one cycle, then the FSM returns to IDLE. Requests are ignored in DONE because the requester's req still reflects the completed access.
- Streak counter, width $clog2(STREAK_MAX+1):
  - Increments on an M grant while if_req=1.
  - Clears on an M grant while if_req=0.
  - Clears on any IF grant.
  - Saturates at STREAK_MAX.
- For writes, m_rdata returns whatever mem_rdata was at ack; M ignores it.
- stall_F and stall_M are combinational from req and ready. The stage advances on the edge that ends its ready cycle.

## Timing
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ready=0, m_ready=0, if_rdata=0, m_rdata=0, streak=0, err=0, timeout counter=0.
- Latency: request seen in IDLE at cycle 0, mem_req from cycle 1. With ack in cycle 1+W (W wait states), ready is high in cycle 2+W and IDLE is reached in cycle 3+W.
- Best-case throughput is one access per 3 cycles.
- A request that arrives during BUSY or DONE waits; it is arbitrated in the next IDLE cycle.
- mem_ack in IDLE or DONE is ignored.
- Requesters must not change addr, wdata or we while req=1 and ready=0. Deasserting req mid-transaction does not abort it; ready still pulses.
- rst in any state, including mid-BUSY, returns all registers to reset values on that edge. The in-flight transaction is abandoned and no ready pulse is issued.

## Configuration
- MEMARB_TIMEOUT_EN defined:
  - A BUSY cycle counter runs, width $clog2(TIMEOUT+1).
  - If TIMEOUT cycles elapse in BUSY without mem_ack, mem_req drops, the owner's rdata is set to 0, err is set and the FSM moves to DONE, so ready still pulses.
  - err stays set until rst.
  - An ack arriving in the same cycle the limit is reached wins; err is not set.
- MEMARB_TIMEOUT_EN undefined: no counter, BUSY waits indefinitely and err is tied 0.

## Test plan
- IF only: if_addr=0x4, mem_ack in cycle 1 with mem_rdata=0x2002000A -> mem_req=1 and mem_addr=0x4 in cycle 1; if_ready=1 and if_rdata=0x2002000A in cycle 2; stall_F=1 in cycles 0–1, 0 in cycle 2.
- Contention: if_req and m_req both raised in cycle 0, m_addr=0x10 -> first mem_addr=0x10; IF granted in the following IDLE cycle; stall_F stays high throughout.
- Streak: m_req kept high with a new address after each m_ready, if_req held -> 4 M grants, 5th grant to IF, streak=0 afterwards.
- Store with waits: m_we=1, m_addr=0x20, m_wdata=0x55, mem_ack after 3 wait states -> mem_we/addr/wdata stable for 4 cycles; m_ready is a single-cycle pulse one cycle after ack.
- Reset mid-BUSY: rst in the 2nd BUSY cycle -> next cycle mem_req=0, state IDLE, no ready pulse; a later ack is ignored.
- MEMARB_TIMEOUT_EN, no ack -> after 255 BUSY cycles mem_req=0, m_ready=1, m_rdata=0, err=1 and held until rst.
